// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-port signals around mem_arbiter.
// slave is the arbiter's view; master is the view of everything around it.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              if_err;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_done;
  logic              ls_err;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_ready;

  logic              busy;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_addr, ls_wdata,
    input  mem_read_data, mem_ready,
    output if_rdata, if_done, if_err,
    output ls_rdata, ls_done, ls_err,
    output mem_address, mem_write_data, mem_read, mem_write,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_addr, ls_wdata,
    output mem_read_data, mem_ready,
    input  if_rdata, if_done, if_err,
    input  ls_rdata, ls_done, ls_err,
    input  mem_address, mem_write_data, mem_read, mem_write,
    input  busy
  );

endinterface

// File: rtl/mem_arbiter.sv
// Serialises fetch (IF) and load/store (LS) transactions onto one memory port.
// LS has priority, bounded by an IF starvation streak; BUSY is bounded by a timeout.
module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_LS_STREAK  = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(MAX_LS_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);
  localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;

  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              if_done_q, if_done_d;
  logic              if_err_q, if_err_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              ls_done_q, ls_done_d;
  logic              ls_err_q, ls_err_d;
  logic              busy_q;

  logic              grant_ls;
  logic              grant_if;
  logic              mem_expired;
  logic              finish;
  logic [DATA_W-1:0] rsp_data;

  // LS wins any contention unless IF has already been passed over MAX_LS_STREAK times.
  assign grant_ls    = bus.ls_req && !(bus.if_req && (streak_q == STREAK_MAX));
  assign grant_if    = bus.if_req && !grant_ls;
  // A ready arriving on the last allowed cycle still counts as success.
  assign mem_expired = !bus.mem_ready && (tcnt_q == TCNT_LAST);
  assign finish      = bus.mem_ready || mem_expired;
  assign rsp_data    = (bus.mem_ready && mem_rd_q) ? bus.mem_read_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_ls || grant_if) state_d = BUSY;
      BUSY:    if (finish) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    streak_d    = streak_q;
    tcnt_d      = tcnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_done_d   = 1'b0;
    if_err_d    = 1'b0;
    ls_done_d   = 1'b0;
    ls_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_ls) begin
          owner_d     = OWN_LS;
          mem_addr_d  = bus.ls_addr;
          mem_wdata_d = bus.ls_wdata;
          mem_rd_d    = !bus.ls_we;
          mem_wr_d    = bus.ls_we;
          tcnt_d      = '0;
          if (!bus.if_req) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + SW'(1);
          end
        end else if (grant_if) begin
          owner_d     = OWN_IF;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          mem_rd_d    = 1'b1;
          mem_wr_d    = 1'b0;
          tcnt_d      = '0;
          streak_d    = '0;
        end
      end

      BUSY: begin
        if (finish) begin
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (owner_q == OWN_LS) begin
            ls_rdata_d = rsp_data;
            ls_done_d  = 1'b1;
            ls_err_d   = mem_expired;
          end else begin
            if_rdata_d = rsp_data;
            if_done_d  = 1'b1;
            if_err_d   = mem_expired;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      default: ;
    endcase
  end

  // Output and bookkeeping registers; reset clears every visible output.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= OWN_IF;
      streak_q    <= '0;
      tcnt_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      if_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      if_err_q    <= 1'b0;
      ls_rdata_q  <= '0;
      ls_done_q   <= 1'b0;
      ls_err_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      tcnt_q      <= tcnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      if_rdata_q  <= if_rdata_d;
      if_done_q   <= if_done_d;
      if_err_q    <= if_err_d;
      ls_rdata_q  <= ls_rdata_d;
      ls_done_q   <= ls_done_d;
      ls_err_q    <= ls_err_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.mem_address    = mem_addr_q;
  assign bus.mem_write_data = mem_wdata_q;
  assign bus.mem_read       = mem_rd_q;
  assign bus.mem_write      = mem_wr_q;
  assign bus.if_rdata       = if_rdata_q;
  assign bus.if_done        = if_done_q;
  assign bus.if_err         = if_err_q;
  assign bus.ls_rdata       = ls_rdata_q;
  assign bus.ls_done        = ls_done_q;
  assign bus.ls_err         = ls_err_q;
  assign bus.busy           = busy_q;

endmodule
